// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default PCM width and the DAC serializer state encoding.
package audio_pkg;

  localparam int unsigned DAC_N_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT_L = 2'd1,
    WAIT_R  = 2'd2,
    SHIFT_R = 2'd3
  } dac_state_t;

endpackage

// File: rtl/lrc_edge_detect.sv
// DACLRC edge detector in the BCLK domain; the fall output exists only when DAC_STREAM_STEREO_DUP_EN is defined.
module lrc_edge_detect (
  input  logic bclk_i,
  input  logic reset_i,
  input  logic daclrc_i,
`ifdef DAC_STREAM_STEREO_DUP_EN
  output logic fall_o,
`endif
  output logic rise_o
);

  logic lrc_q;

  // Preset high in reset so a daclrc already high at release is not seen as a frame start.
  always_ff @(posedge bclk_i) begin
    if (reset_i) begin
      lrc_q <= 1'b1;
    end else begin
      lrc_q <= daclrc_i;
    end
  end

  assign rise_o = daclrc_i & ~lrc_q;
`ifdef DAC_STREAM_STEREO_DUP_EN
  assign fall_o = ~daclrc_i & lrc_q;
`endif

endmodule

// File: rtl/dac_stream.sv
// Left-justified MSB-first DAC serializer with one-entry holding register.
// Build option DAC_STREAM_STEREO_DUP_EN re-emits the left sample in the right half-frame.
module dac_stream
  import audio_pkg::*;
#(
  parameter int unsigned N = DAC_N_DEFAULT
) (
  input  logic         bclk,
  input  logic         reset,
  input  logic         daclrc,
  input  logic [N-1:0] sample_data,
  input  logic         valid,
  output logic         ready,
  output logic         dacdat,
  output logic         underrun
);

  localparam int unsigned CW = $clog2(N);

  dac_state_t   state_q, state_d;
  logic [N-1:0] hold_q, hold_d;
  logic         hold_full_q, hold_full_d;
  logic [N-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         dacdat_q, dacdat_d;
  logic         underrun_q, underrun_d;
  logic [N-1:0] load_s;
  logic         rise_s;
  logic         accept_s;
`ifdef DAC_STREAM_STEREO_DUP_EN
  logic         fall_s;
  logic [N-1:0] cur_q, cur_d;
`endif

  lrc_edge_detect u_lrc_edge (
    .bclk_i   (bclk),
    .reset_i  (reset),
    .daclrc_i (daclrc),
`ifdef DAC_STREAM_STEREO_DUP_EN
    .fall_o   (fall_s),
`endif
    .rise_o   (rise_s)
  );

  assign ready    = ~hold_full_q & ~reset;
  assign accept_s = valid & ready;
  assign load_s   = hold_full_q ? hold_q : {N{1'b0}};

  // Next-state: hold register, frame start/abort, and bit shifting.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    dacdat_d    = 1'b0;
    underrun_d  = 1'b0;
`ifdef DAC_STREAM_STEREO_DUP_EN
    cur_d       = cur_q;
`endif

    // A same-edge accept only happens with hold empty, so it must win over the frame's clear.
    if (accept_s) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end else if (rise_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end

    if (rise_s) begin
      underrun_d = ~hold_full_q;
      state_d    = SHIFT_L;
      dacdat_d   = load_s[N-1];
      shift_d    = {load_s[N-2:0], 1'b0};
      cnt_d      = CW'(N - 1);
`ifdef DAC_STREAM_STEREO_DUP_EN
      cur_d      = load_s;
    end else if (fall_s && (state_q == SHIFT_L || state_q == WAIT_R)) begin
      state_d    = SHIFT_R;
      dacdat_d   = cur_q[N-1];
      shift_d    = {cur_q[N-2:0], 1'b0};
      cnt_d      = CW'(N - 1);
`endif
    end else begin
      case (state_q)
        SHIFT_L, SHIFT_R: begin
          if (cnt_q != {CW{1'b0}}) begin
            dacdat_d = shift_q[N-1];
            shift_d  = {shift_q[N-2:0], 1'b0};
            cnt_d    = cnt_q - CW'(1);
          end else begin
`ifdef DAC_STREAM_STEREO_DUP_EN
            state_d = (state_q == SHIFT_L) ? WAIT_R : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
        default: begin
          dacdat_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= {N{1'b0}};
      hold_full_q <= 1'b0;
      shift_q     <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
      dacdat_q    <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef DAC_STREAM_STEREO_DUP_EN
      cur_q       <= {N{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dacdat_q    <= dacdat_d;
      underrun_q  <= underrun_d;
`ifdef DAC_STREAM_STEREO_DUP_EN
      cur_q       <= cur_d;
`endif
    end
  end

  assign dacdat   = dacdat_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_stream.sv
// Self-checking bench for dac_stream: per-cycle scoreboard of expected dacdat/underrun.
module tb_dac_stream;

  localparam int N = 16;
  localparam int F = 20;

  typedef struct packed {
    logic d;
    logic u;
  } exp_t;

  typedef struct {
    bit          push;
    logic [15:0] val;
    bit          exp_ur;
  } vec_t;

  logic          bclk = 1'b0;
  logic          reset;
  logic          daclrc;
  logic [N-1:0]  sample_data;
  logic          valid;
  logic          ready;
  logic          dacdat;
  logic          underrun;

  exp_t          exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            pend = 1'b0;
  logic [15:0]   pend_val = 16'h0000;
  vec_t          vecs[6];

  dac_stream #(.N(N)) dut (
    .bclk        (bclk),
    .reset       (reset),
    .daclrc      (daclrc),
    .sample_data (sample_data),
    .valid       (valid),
    .ready       (ready),
    .dacdat      (dacdat),
    .underrun    (underrun)
  );

  always #5 bclk = ~bclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %b want %b", name, cyc, got, want);
    end
  endtask

  task automatic push_exp(input logic d, input logic u);
    exp_t e;
    e.d = d;
    e.u = u;
    exp_q.push_back(e);
  endtask

  // One clock: drive pending sample, clock, then compare one scoreboard entry.
  task automatic step();
    bit   rdy_before;
    exp_t e;
    valid       = pend;
    sample_data = pend_val;
    rdy_before  = ready;
    @(posedge bclk);
    #1;
    cyc++;
    if (pend && rdy_before) pend = 1'b0;
    valid = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check1("dacdat", dacdat, e.d);
      check1("underrun", underrun, e.u);
    end
  endtask

  task automatic push_sample(input logic [15:0] v);
    int k;
    pend     = 1'b1;
    pend_val = v;
    k = 0;
    while (pend && k < 10) begin
      step();
      k++;
    end
    if (pend) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got ready stuck low want accept within 10 cycles");
      pend = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] v, input bit ur);
    daclrc = 1'b1;
    for (int i = 0; i < N; i++) push_exp(v[N-1-i], (i == 0) ? ur : 1'b0);
    for (int i = N; i < F; i++) push_exp(1'b0, 1'b0);
    repeat (F) step();
    daclrc = 1'b0;
`ifdef DAC_STREAM_STEREO_DUP_EN
    for (int i = 0; i < N; i++) push_exp(v[N-1-i], 1'b0);
`else
    for (int i = 0; i < N; i++) push_exp(1'b0, 1'b0);
`endif
    for (int i = N; i < F; i++) push_exp(1'b0, 1'b0);
    repeat (F) step();
  endtask

  initial begin
    vecs[0] = '{push: 1'b1, val: 16'hA5C3, exp_ur: 1'b0};
    vecs[1] = '{push: 1'b0, val: 16'h0000, exp_ur: 1'b1};
    vecs[2] = '{push: 1'b1, val: 16'h7FFF, exp_ur: 1'b0};
    vecs[3] = '{push: 1'b1, val: 16'h0001, exp_ur: 1'b0};
    vecs[4] = '{push: 1'b1, val: 16'hFFFF, exp_ur: 1'b0};
    vecs[5] = '{push: 1'b1, val: 16'h8000, exp_ur: 1'b0};

    reset       = 1'b1;
    daclrc      = 1'b1;
    valid       = 1'b0;
    sample_data = '0;
    repeat (3) step();
    check1("ready_in_reset", ready, 1'b0);
    check1("dacdat_in_reset", dacdat, 1'b0);
    check1("underrun_in_reset", underrun, 1'b0);

    // Release with daclrc high: no frame start until the next rising edge.
    reset = 1'b0;
    for (int i = 0; i < F; i++) push_exp(1'b0, 1'b0);
    repeat (F) step();
    check1("ready_after_reset", ready, 1'b1);
    daclrc = 1'b0;
    repeat (5) step();

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].push) push_sample(vecs[v].val);
      frame(vecs[v].push ? vecs[v].val : 16'h0000, vecs[v].exp_ur);
    end

    // Accept on the frame-start edge with hold empty: zeros now, sample next frame.
    pend     = 1'b1;
    pend_val = 16'h8001;
    frame(16'h0000, 1'b1);
    check1("simul_accepted", pend, 1'b0);
    frame(16'h8001, 1'b0);

    // Hold full with valid held: no overwrite, accepted right after frame start.
    push_sample(16'h5A5A);
    pend     = 1'b1;
    pend_val = 16'h1234;
    repeat (3) begin
      step();
      check1("ready_hold_full", ready, 1'b0);
    end
    frame(16'h5A5A, 1'b0);
    check1("held_valid_accepted", pend, 1'b0);
    frame(16'h1234, 1'b0);

    // Short frame: a new rising edge aborts the current shift.
    push_sample(16'hF00F);
    daclrc = 1'b1;
    for (int i = 0; i < 8; i++) push_exp((i < 4) ? 1'b1 : 1'b0, 1'b0);
    repeat (8) step();
    daclrc = 1'b0;
`ifdef DAC_STREAM_STEREO_DUP_EN
    push_exp(1'b1, 1'b0);
    push_exp(1'b1, 1'b0);
`else
    push_exp(1'b0, 1'b0);
    push_exp(1'b0, 1'b0);
`endif
    repeat (2) step();
    frame(16'h0000, 1'b1);

    // Reset mid-shift clears everything and masks the high daclrc at release.
    push_sample(16'hC3C3);
    daclrc = 1'b1;
    push_exp(1'b1, 1'b0);
    push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b0);
    push_exp(1'b0, 1'b0);
    push_exp(1'b0, 1'b0);
    repeat (5) step();
    reset = 1'b1;
    push_exp(1'b0, 1'b0);
    step();
    check1("ready_mid_reset", ready, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < F; i++) push_exp(1'b0, 1'b0);
    repeat (F) step();
    check1("hold_cleared_ready", ready, 1'b1);
    daclrc = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0);
    repeat (4) step();
    frame(16'h0000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
